// File: rtl/hex_dump_sequencer_pkg.sv
// Shared constants and types for the hex dump sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: ASCII character codes used on the transmit stream, the dump FSM
// state encoding and the default dump length.
package dump_pkg;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam int DUMP_LEN_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    HI,
    LO,
    SEP,
    CR,
    LF
  } state_t;

endpackage

// File: rtl/hex_dump_sequencer_nibble_to_ascii.sv
// Converts one 4-bit nibble into its uppercase ASCII hex digit.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   nib  in  4  nibble value 0..15
//   chr  out 8  ASCII '0'..'9' or 'A'..'F'
module nibble_to_ascii
  import dump_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    if (nib < 4'd10) begin
      chr = ASCII_ZERO + {4'd0, nib};
    end else begin
      chr = ASCII_A + {4'd0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_dump_sequencer.sv
// Command-driven hex dump: a received byte is a start address, DUMP_LEN bytes are read and sent as "HH HH .. HH\r\n".
// Latency: rd_addr valid 1 cycle after rx_stb; first tx_start 2+RD_LAT cycles after rx_stb when the transmitter is idle.
// Backpressure: each character waits for tx_busy=0; commands arriving while a dump is active are dropped and flagged on overrun.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_stb, rx_dat    received command strobe and byte (start address)
//   rd_addr, rd_data  byte read port; data valid RD_LAT cycles after the address
//   tx_dat, tx_start  character and one-cycle trigger to the shared transmitter
//   tx_busy           transmitter active
//   busy              dump in progress
//   overrun           one-cycle pulse when a command was dropped
module hex_dump_sequencer
  import dump_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DUMP_LEN = DUMP_LEN_DEFAULT,
  parameter int RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_stb,
  input  logic [7:0]    rx_dat,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    tx_dat,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic          busy,
  output logic          overrun
);

  localparam logic [7:0] LAST_IDX = 8'(DUMP_LEN - 1);
  localparam logic [1:0] LAT      = 2'(RD_LAT);

  state_t     state;
  logic [7:0] byte_cnt;
  logic [1:0] lat_cnt;
  logic [7:0] hold;
  logic       tx_start_q;

  logic [7:0] hi_chr;
  logic [7:0] lo_chr;
  logic [7:0] send_chr;
  logic       send_st;

  nibble_to_ascii u_hi (
    .nib (hold[7:4]),
    .chr (hi_chr)
  );

  nibble_to_ascii u_lo (
    .nib (hold[3:0]),
    .chr (lo_chr)
  );

  // Character presented by each send state; zero outside the send states
  // so tx_dat rests at 0 while idle or reading.
  always_comb begin
    send_chr = 8'h00;
    send_st  = 1'b1;
    case (state)
      HI:      send_chr = hi_chr;
      LO:      send_chr = lo_chr;
      SEP:     send_chr = ASCII_SP;
      CR:      send_chr = ASCII_CR;
      LF:      send_chr = ASCII_LF;
      default: send_st  = 1'b0;
    endcase
  end

  // The trigger is decoded from registered state so the first character can
  // go out in the very cycle HI is entered. tx_start_q blanks the cycle right
  // after a pulse, when the transmitter may not have raised tx_busy yet.
  assign tx_start = send_st && !tx_busy && !tx_start_q && !rst;
  assign tx_dat   = send_chr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      byte_cnt   <= 8'd0;
      lat_cnt    <= 2'd0;
      hold       <= 8'd0;
      tx_start_q <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_start_q <= tx_start;
      // Any command outside IDLE is dropped, including the LF-pulse cycle
      // where busy is about to fall.
      overrun    <= rx_stb && (state != IDLE);

      case (state)
        IDLE: begin
          if (rx_stb) begin
            rd_addr  <= AW'(rx_dat);
            byte_cnt <= 8'd0;
            lat_cnt  <= 2'd0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end

        // lat_cnt counts cycles since rd_addr last changed; the data is
        // sampled exactly once, when it reaches the read latency.
        READ: begin
          if (lat_cnt == LAT) begin
            hold  <= rd_data;
            state <= HI;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        HI: begin
          if (tx_start) state <= LO;
        end

        LO: begin
          if (tx_start) state <= (byte_cnt == LAST_IDX) ? CR : SEP;
        end

        SEP: begin
          if (tx_start) begin
            rd_addr  <= rd_addr + AW'(1);
            byte_cnt <= byte_cnt + 8'd1;
            lat_cnt  <= 2'd0;
            state    <= READ;
          end
        end

        CR: begin
          if (tx_start) state <= LF;
        end

        LF: begin
          if (tx_start) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hex_dump_sequencer.md
Name: hex_dump_sequencer

Overview:
- Command-driven dump controller placed between the UART receiver/transmitter pair and a byte-addressed register/dispatcher read port.
- A received command byte is taken as a start address. The block reads DUMP_LEN consecutive bytes and emits them as uppercase ASCII hex over the shared transmitter: space-separated, terminated by CR LF.
- It owns sequencing of the read port and the transmitter start/busy handshake.

Parameters:
- AW, 8, read-address width; command byte zero-extended/truncated to AW bits.
- DUMP_LEN, 16, bytes per dump; legal range 1..255.
- RD_LAT, 1, read-port latency in cycles from rd_addr change to valid rd_data; legal range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_stb  in  1  one-cycle strobe, received byte valid
- rx_dat  in  8  received command byte
- rd_addr  out  AW  read address to dispatcher
- rd_data  in  8  read data, valid RD_LAT cycles after rd_addr
- tx_dat  out  8  character to transmit
- tx_start  out  1  one-cycle transmit trigger
- tx_busy  in  1  transmitter active
- busy  out  1  dump in progress
- overrun  out  1  one-cycle pulse, command dropped while busy

Behaviour:
- Reset values: rd_addr=0, tx_dat=0, tx_start=0, busy=0, overrun=0, state=IDLE, byte counter=0, latency counter=0.
- Reset mid-dump: the cycle after rst, all outputs are at reset values. No partial line is completed. tx_start is never asserted while rst=1.
- FSM states: IDLE, READ, HI, LO, SEP, CR, LF.
- IDLE:
  - rx_stb=1 -> rd_addr<=rx_dat[AW-1:0], byte count<=0, busy<=1, go READ.
- READ:
  - Wait RD_LAT cycles, then capture rd_data into a holding register and go HI.
  - With RD_LAT=0, capture occurs in the first READ cycle.
- Send states HI, LO, SEP, CR, LF:
  - Pulse tx_start for one cycle with tx_dat set in the same cycle, when tx_busy=0 and tx_start was 0 on the previous cycle.
  - tx_busy is not sampled in the cycle immediately after a pulse. The transmitter raises tx_busy by then.
  - After the pulse, advance state.
- Transitions:
  - HI (high nibble) -> LO (low nibble).
  - LO -> SEP if count<DUMP_LEN-1, else CR.
  - SEP (0x20) -> rd_addr<=rd_addr+1 (mod 2^AW wrap), count<=count+1, go READ.
  - CR (0x0D) -> LF (0x0A).
  - LF -> IDLE, busy<=0 in the cycle after the LF pulse.
- Nibble encoding: 0..9 -> 0x30+n; 10..15 -> 0x41+(n-10). Uppercase only.
- Character count per dump: 3*DUMP_LEN+1 (49 for the default).
- Latency: with rx_stb at cycle t and tx idle, rd_addr is valid at t+1 and the first tx_start is at t+2+RD_LAT.
- Address wrap: start address 0xFE with DUMP_LEN=4 reads FE, FF, 00, 01. No error is flagged.
- rx_stb while busy=1: byte discarded, overrun pulses the next cycle, dump continues unaffected.
- rx_stb in the same cycle busy falls (the LF-completion cycle): treated as busy, dropped, overrun.
- rd_data changes outside the capture cycle: no effect. The holding register is stable through HI and LO.

Decomposition:
- Shared package dump_pkg:
  - ASCII constants SP/CR/LF/ZERO/A.
  - FSM state enum.
  - DUMP_LEN default.
- One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out), instanced twice or muxed.
- Transmitter handshake pacing stays inline.

Test Plan:
- Reset, then rx_stb with rx_dat=0x10, DUMP_LEN=4, memory 10:0x3A, 11:0x00, 12:0xFF, 13:0x9C.
  - Required: transmitted stream "3A 00 FF 9C" then 0x0D 0x0A, 13 chars.
  - Required: busy falls after the LF pulse.
- Start 0xFE, DUMP_LEN=4.
  - Required: rd_addr sequence FE, FF, 00, 01 and hex of those four locations.
- Second rx_stb during a dump.
  - Required: overrun pulses exactly once, stream unchanged, no second dump.
- tx_busy held high 1000 cycles per character.
  - Required: no tx_start while tx_busy=1.
  - Required: never two tx_start pulses on consecutive cycles.
  - Required: exactly 49 pulses for DUMP_LEN=16.
- rst asserted after the 5th character.
  - Required: tx_start=0, busy=0 next cycle.
  - Required: a new command afterwards produces a complete correct line.
- RD_LAT=0 and RD_LAT=3 builds, rx_stb at cycle t.
  - Required: first tx_start at t+2 and t+5 respectively.
  - Required: data is correct in both builds.
